// File: rtl/cmd_rcv.sv
// Far-end command responder: assembles fixed-length multi-byte commands from a UART
// receiver for the command processor and returns a single acknowledge byte on request.
module cmd_rcv #(
  parameter int         CMD_BYTES = 3,
  parameter int         TIMEOUT   = 50000,
  parameter logic [7:0] RESP_BYTE = 8'h0A
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rx_rdy,
  output logic [8*CMD_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic                   frame_err,
  input  logic                   send_resp,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  input  logic                   tx_done,
  output logic                   resp_sent
);

  localparam int CW = 8 * CMD_BYTES;
  localparam int AW = CW - 8;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int NW = $clog2(CMD_BYTES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [NW-1:0] CNT_LAST = NW'(CMD_BYTES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, READY} rx_state_e;
  typedef enum logic {TIDLE, TWAIT} tx_state_e;

  rx_state_e       rx_state_q, rx_state_d;
  tx_state_e       tx_state_q, tx_state_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  // Holds the first CMD_BYTES-1 bytes; the final byte goes straight into cmd.
  logic [AW-1:0]   asm_q, asm_d;
  logic [CW-1:0]   cmd_q, cmd_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            frame_err_q, frame_err_d;
  logic            trmt_q, trmt_d;
  logic            resp_sent_q, resp_sent_d;
  logic            accept;

  assign accept     = rx_rdy & (rx_state_q != READY) & ~rst;
  assign clr_rx_rdy = accept;
  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign frame_err  = frame_err_q;
  assign trmt       = trmt_q;
  assign resp_sent  = resp_sent_q;
  assign tx_data    = RESP_BYTE;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q  <= IDLE;
      tx_state_q  <= TIDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      asm_q       <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      tx_state_q  <= tx_state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      asm_q       <= asm_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      frame_err_q <= frame_err_d;
      trmt_q      <= trmt_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    asm_d       = asm_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    frame_err_d = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (accept) begin
          asm_d      = AW'(rx_data);
          cnt_d      = NW'(1);
          tmo_d      = '0;
          rx_state_d = COLLECT;
        end
      end
      COLLECT: begin
        // An arriving byte beats a simultaneous timeout expiry.
        if (accept) begin
          tmo_d = '0;
          if (cnt_q == CNT_LAST) begin
            cmd_d      = {asm_q, rx_data};
            cmd_rdy_d  = 1'b1;
            cnt_d      = '0;
            rx_state_d = READY;
          end else begin
            asm_d = AW'({asm_q, rx_data});
            cnt_d = cnt_q + NW'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          tmo_d       = '0;
          asm_d       = '0;
          rx_state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      READY: begin
        if (clr_cmd_rdy) begin
          cmd_rdy_d  = 1'b0;
          rx_state_d = IDLE;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    trmt_d      = 1'b0;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      TIDLE: begin
        if (send_resp) begin
          trmt_d     = 1'b1;
          tx_state_d = TWAIT;
        end
      end
      TWAIT: begin
        if (tx_done) begin
          resp_sent_d = 1'b1;
          tx_state_d  = TIDLE;
        end
      end
      default: tx_state_d = TIDLE;
    endcase
  end

endmodule
